// File: rtl/stall_controller_pkg.sv
// Shared types for the stall controller: FSM states, branch_id encodings,
// hazard classification and the register-match helper.
package stall_ctrl_pkg;

  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HOLD1 = 2'd1,
    ST_DIV   = 2'd2
  } state_e;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_COND = 2'b01;
  localparam logic [1:0] BR_JALR = 2'b10;

  typedef enum logic [2:0] {
    HZ_NONE,
    HZ_LOAD_USE,
    HZ_BR_ALU,
    HZ_BR_LD_EX,
    HZ_BR_LD_MEM
  } hazard_kind_e;

  // x0 is hardwired to zero, so a write to it can never feed a consumer.
  function automatic logic src_match(input logic [4:0] rd, input logic [4:0] rs,
                                     input logic used, input logic wr);
    return wr && used && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/stall_controller_if.sv
// Pipeline <-> stall controller bundle: hazard inputs from ID/EX/MEM and
// the stall/enable/flush controls driven back into the pipeline.
interface stall_controller_if;
  logic [4:0] rs1_id;
  logic [4:0] rs2_id;
  logic       rs1_used_id;
  logic       rs2_used_id;
  logic [1:0] branch_id;
  logic       branch_taken_id;
  logic [4:0] rd_ex;
  logic [4:0] rd_mem;
  logic       reg_write_ex;
  logic       reg_write_mem;
  logic       mem_to_reg_ex;
  logic       mem_to_reg_mem;
  logic       div_start_ex;
  logic       stall;
  logic       pc_en;
  logic       if_id_en;
  logic       id_ex_flush;
  logic       if_id_flush;
  logic       ex_hold;

  modport master (
    output rs1_id, rs2_id, rs1_used_id, rs2_used_id, branch_id, branch_taken_id,
           rd_ex, rd_mem, reg_write_ex, reg_write_mem, mem_to_reg_ex,
           mem_to_reg_mem, div_start_ex,
    input  stall, pc_en, if_id_en, id_ex_flush, if_id_flush, ex_hold
  );

  modport slave (
    input  rs1_id, rs2_id, rs1_used_id, rs2_used_id, branch_id, branch_taken_id,
           rd_ex, rd_mem, reg_write_ex, reg_write_mem, mem_to_reg_ex,
           mem_to_reg_mem, div_start_ex,
    output stall, pc_en, if_id_en, id_ex_flush, if_id_flush, ex_hold
  );
endinterface

// File: rtl/stall_controller_hazard_detect.sv
// Combinational data-hazard classifier: reports whether the ID instruction
// needs a one-cycle or a two-cycle stall against producers in EX/MEM.
module hazard_detect
  import stall_ctrl_pkg::*;
(
  input  logic [4:0] rs1_id,
  input  logic [4:0] rs2_id,
  input  logic       rs1_used_id,
  input  logic       rs2_used_id,
  input  logic [1:0] branch_id,
  input  logic [4:0] rd_ex,
  input  logic [4:0] rd_mem,
  input  logic       reg_write_ex,
  input  logic       reg_write_mem,
  input  logic       mem_to_reg_ex,
  input  logic       mem_to_reg_mem,
  output logic       hazard_1clk,
  output logic       hazard_2clk
);

  logic         hit_ex;
  logic         hit_mem;
  logic         is_branch;
  hazard_kind_e kind;

  // Branches compare in ID, so they need operands one stage earlier than ALU ops.
  always_comb begin
    hit_ex    = src_match(rd_ex, rs1_id, rs1_used_id, reg_write_ex) |
                src_match(rd_ex, rs2_id, rs2_used_id, reg_write_ex);
    hit_mem   = src_match(rd_mem, rs1_id, rs1_used_id, reg_write_mem) |
                src_match(rd_mem, rs2_id, rs2_used_id, reg_write_mem);
    is_branch = (branch_id == BR_COND) || (branch_id == BR_JALR);
    kind      = HZ_NONE;
    if (hit_ex) begin
      if (!is_branch) begin
        if (mem_to_reg_ex) kind = HZ_LOAD_USE;
      end else if (mem_to_reg_ex) begin
        kind = HZ_BR_LD_EX;
      end else begin
        kind = HZ_BR_ALU;
      end
    end else if (is_branch && mem_to_reg_mem && hit_mem) begin
      kind = HZ_BR_LD_MEM;
    end
  end

  assign hazard_2clk = (kind == HZ_BR_LD_EX);
  assign hazard_1clk = (kind == HZ_LOAD_USE) || (kind == HZ_BR_ALU) ||
                       (kind == HZ_BR_LD_MEM);

endmodule

// File: rtl/stall_controller.sv
// Pipeline stall controller FSM (RUN/HOLD1/DIV). Define STALL_CTRL_DIV_STALL_EN
// to enable the multi-cycle divide stall; otherwise div_start_ex is ignored.
module stall_controller
  import stall_ctrl_pkg::*;
#(
  parameter int DIV_LATENCY = 34
) (
  input logic          clk,
  input logic          reset,
  stall_controller_if.slave bus
);

  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LATENCY - 1);

  state_e state_q, state_d;
  logic   hazard_1clk;
  logic   hazard_2clk;
  logic   div_go;

  hazard_detect u_hazard_detect (
    .rs1_id         (bus.rs1_id),
    .rs2_id         (bus.rs2_id),
    .rs1_used_id    (bus.rs1_used_id),
    .rs2_used_id    (bus.rs2_used_id),
    .branch_id      (bus.branch_id),
    .rd_ex          (bus.rd_ex),
    .rd_mem         (bus.rd_mem),
    .reg_write_ex   (bus.reg_write_ex),
    .reg_write_mem  (bus.reg_write_mem),
    .mem_to_reg_ex  (bus.mem_to_reg_ex),
    .mem_to_reg_mem (bus.mem_to_reg_mem),
    .hazard_1clk    (hazard_1clk),
    .hazard_2clk    (hazard_2clk)
  );

`ifdef STALL_CTRL_DIV_STALL_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign div_go = bus.div_start_ex;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_RUN && div_go) begin
      cnt_d = DIV_LOAD;
    end else if (state_q == ST_DIV && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  logic unused_div;

  assign div_go     = 1'b0;
  assign unused_div = ^{bus.div_start_ex, DIV_LOAD};
`endif

  // Outputs are forced to run values while reset is held, whatever the state.
  always_comb begin
    state_d         = state_q;
    bus.stall       = 1'b0;
    bus.pc_en       = 1'b1;
    bus.if_id_en    = 1'b1;
    bus.id_ex_flush = 1'b0;
    bus.if_id_flush = 1'b0;
    bus.ex_hold     = 1'b0;
    if (reset) begin
      case (state_q)
        ST_RUN: begin
          if (div_go) begin
            state_d         = ST_DIV;
            bus.if_id_flush = bus.branch_taken_id;
          end else if (hazard_1clk || hazard_2clk) begin
            bus.stall       = 1'b1;
            bus.pc_en       = 1'b0;
            bus.if_id_en    = 1'b0;
            bus.id_ex_flush = 1'b1;
            if (hazard_2clk) state_d = ST_HOLD1;
          end else begin
            bus.if_id_flush = bus.branch_taken_id;
          end
        end
        ST_HOLD1: begin
          bus.stall       = 1'b1;
          bus.pc_en       = 1'b0;
          bus.if_id_en    = 1'b0;
          bus.id_ex_flush = 1'b1;
          state_d         = ST_RUN;
        end
        default: begin
`ifdef STALL_CTRL_DIV_STALL_EN
          bus.stall    = 1'b1;
          bus.ex_hold  = 1'b1;
          bus.pc_en    = 1'b0;
          bus.if_id_en = 1'b0;
          if (cnt_q <= 1) state_d = ST_RUN;
`else
          state_d = ST_RUN;
`endif
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

endmodule
